// File: rtl/rf_pkg.sv
// Shared defaults, types and width helpers for the scoreboarded register file.
package rf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef logic [DEF_DATA_W-1:0] rf_data_t;
    typedef logic [DEF_ADDR_W-1:0] rf_addr_t;

    // busy_cnt must hold DEPTH itself, hence DEPTH+1 distinct values.
    function automatic int popcount_w(input int addr_w);
        return $clog2((1 << addr_w) + 1);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking: one in-flight producer per register, RAW lookup
// for each read port, WAW warning on reserve and a running busy count.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int DEPTH   = 2 ** ADDR_W,
    localparam int CNT_W   = popcount_w(ADDR_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_used,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     stall,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_conflict,
    output logic [CNT_W-1:0]         busy_cnt
);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
    logic             wr_ok, rsv_ok, inc, dec;
    logic [ADDR_W-1:0] addr_k;

    always_comb begin
        wr_ok  = wr_en  && !(ZERO_REG != 0 && wr_addr  == '0);
        rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);

        // Reserve is applied last so a new producer wins over a retiring one.
        busy_d = busy_q;
        if (wr_ok)
            busy_d[wr_addr] = 1'b0;
        if (rsv_ok)
            busy_d[rsv_addr] = 1'b1;

        inc = rsv_ok && !busy_q[rsv_addr];
        dec = wr_ok && busy_q[wr_addr] && !(rsv_ok && rsv_addr == wr_addr);
        busy_cnt_d = busy_cnt_q + CNT_W'(inc) - CNT_W'(dec);

        rsv_conflict = rsv_ok && busy_q[rsv_addr];
    end

    always_comb begin
        rd_busy = '0;
        addr_k  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            addr_k     = rd_addr[k*ADDR_W +: ADDR_W];
            rd_busy[k] = busy_q[addr_k];
            if (BYPASS != 0 && wr_ok && wr_addr == addr_k)
                rd_busy[k] = 1'b0;
            if (ZERO_REG != 0 && addr_k == '0)
                rd_busy[k] = 1'b0;
        end
        stall = |(rd_busy & rd_used);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with rising-edge writes, optional write-to-read
// bypass and an integrated busy scoreboard for the hazard unit.
module regfile_sb
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int DEPTH   = 2 ** ADDR_W,
    localparam int CNT_W   = popcount_w(ADDR_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_used,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     stall,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_conflict,
    output logic [CNT_W-1:0]         busy_cnt
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              wr_ok, wr_fwd;
    logic [ADDR_W-1:0] addr_k;
    logic [DATA_W-1:0] data_k;

    always_comb begin
        wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == '0);
        mem_d = mem_q;
        if (wr_ok)
            mem_d[wr_addr] = wr_data;
    end

    // Forwarding is gated by reset so the read ports stay at zero while held.
    always_comb begin
        wr_fwd  = (BYPASS != 0) && wr_en && rst_n;
        rd_data = '0;
        addr_k  = '0;
        data_k  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            addr_k = rd_addr[k*ADDR_W +: ADDR_W];
            data_k = mem_q[addr_k];
            if (wr_fwd && wr_addr == addr_k)
                data_k = wr_data;
            if (ZERO_REG != 0 && addr_k == '0)
                data_k = '0;
            rd_data[k*DATA_W +: DATA_W] = data_k;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_q <= '{default: '0};
        else
            mem_q <= mem_d;
    end

    rf_scoreboard #(
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr),
        .rd_used     (rd_used),
        .rd_busy     (rd_busy),
        .stall       (stall),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .rsv_conflict(rsv_conflict),
        .busy_cnt    (busy_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default build, a no-bypass build sharing its
// inputs, and a 4-port 64-entry build for the full-occupancy scenario.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [9:0]  rd_addr;
    logic [1:0]  rd_used;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    logic [63:0] rd_data, nb_rd_data;
    logic [1:0]  rd_busy, nb_rd_busy;
    logic        stall, nb_stall;
    logic        rsv_conflict, nb_rsv_conflict;
    logic [5:0]  busy_cnt, nb_busy_cnt;

    logic [23:0]  b_rd_addr;
    logic [3:0]   b_rd_used;
    logic [127:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic         b_stall;
    logic         b_wr_en;
    logic [5:0]   b_wr_addr;
    logic [31:0]  b_wr_data;
    logic         b_rsv_en;
    logic [5:0]   b_rsv_addr;
    logic         b_rsv_conflict;
    logic [6:0]   b_busy_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_used(rd_used),
        .rd_data(rd_data), .rd_busy(rd_busy), .stall(stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_conflict(rsv_conflict), .busy_cnt(busy_cnt)
    );

    regfile_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_used(rd_used),
        .rd_data(nb_rd_data), .rd_busy(nb_rd_busy), .stall(nb_stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_conflict(nb_rsv_conflict), .busy_cnt(nb_busy_cnt)
    );

    regfile_sb #(.ADDR_W(6), .NUM_RD(4)) dut_big (
        .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_used(b_rd_used),
        .rd_data(b_rd_data), .rd_busy(b_rd_busy), .stall(b_stall),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
        .rsv_conflict(b_rsv_conflict), .busy_cnt(b_busy_cnt)
    );

    task automatic idle();
        wr_en = 1'b0;  wr_addr = '0;  wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        rd_used = '0;
        b_wr_en = 1'b0;  b_wr_addr = '0;  b_wr_data = '0;
        b_rsv_en = 1'b0; b_rsv_addr = '0;
        b_rd_used = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rd_addr = {5'd5, 5'd5};
        rd_used = 2'b11;
        b_rd_addr = {6'd5, 6'd5, 6'd5, 6'd5};
        rst_n = 1'b0;
        #2;
        total++;
        if (rd_data !== 64'd0) begin
            bad++; $display("[TB] FAIL reset_rd_data: got %h expected 0", rd_data);
        end
        total++;
        if (rd_busy !== 2'b00 || stall !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_busy: got busy=%b stall=%b expected 00/0", rd_busy, stall);
        end
        total++;
        if (busy_cnt !== 6'd0 || b_busy_cnt !== 7'd0) begin
            bad++; $display("[TB] FAIL reset_cnt: got %0d/%0d expected 0/0", busy_cnt, b_busy_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        idle();
        rd_addr = {5'd1, 5'd2};
        rsv_en = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            rsv_addr = 5'(r);
            step();
        end
        rsv_en = 1'b0;
        #1;
        total++;
        if (busy_cnt !== 6'd3) begin
            bad++; $display("[TB] FAIL midrun_cnt3: got %0d expected 3", busy_cnt);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy_cnt !== 6'd0 || rd_busy !== 2'b00) begin
            bad++; $display("[TB] FAIL midrun_async_reset: got cnt=%0d busy=%b expected 0/00", busy_cnt, rd_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_bypass();
        @(negedge clk);
        idle();
        rd_addr = {5'd0, 5'd7};
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
        #1;
        total++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            bad++; $display("[TB] FAIL bypass_same_cycle: got %h expected deadbeef", rd_data[31:0]);
        end
        total++;
        if (nb_rd_data[31:0] !== 32'h0) begin
            bad++; $display("[TB] FAIL nobypass_same_cycle: got %h expected 0", nb_rd_data[31:0]);
        end
        step();
        wr_en = 1'b0;
        #1;
        total++;
        if (rd_data[31:0] !== 32'hDEADBEEF || nb_rd_data[31:0] !== 32'hDEADBEEF) begin
            bad++; $display("[TB] FAIL write_next_cycle: got %h/%h expected deadbeef", rd_data[31:0], nb_rd_data[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle();
        rd_addr = {5'd0, 5'd3};
        rd_used = 2'b01;
        rsv_en = 1'b1; rsv_addr = 5'd3;
        #1;
        total++;
        if (rd_busy[0] !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("[TB] FAIL rsv_latency: got busy=%b stall=%b expected 0/0", rd_busy[0], stall);
        end
        step();
        rsv_en = 1'b0;
        #1;
        total++;
        if (rd_busy[0] !== 1'b1 || stall !== 1'b1 || busy_cnt !== 6'd1) begin
            bad++; $display("[TB] FAIL rsv_busy: got busy=%b stall=%b cnt=%0d expected 1/1/1", rd_busy[0], stall, busy_cnt);
        end
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        #1;
        total++;
        if (stall !== 1'b0 || nb_stall !== 1'b1) begin
            bad++; $display("[TB] FAIL wb_stall_drop: got bypass=%b nobypass=%b expected 0/1", stall, nb_stall);
        end
        step();
        wr_en = 1'b0;
        #1;
        total++;
        if (busy_cnt !== 6'd0 || nb_busy_cnt !== 6'd0 || nb_stall !== 1'b0) begin
            bad++; $display("[TB] FAIL wb_clear: got cnt=%0d/%0d nbstall=%b expected 0/0/0", busy_cnt, nb_busy_cnt, nb_stall);
        end
    endtask

    task automatic test_rsv_wr_same();
        @(negedge clk);
        idle();
        rd_addr = {5'd4, 5'd0};
        rsv_en = 1'b1; rsv_addr = 5'd4;
        wr_en = 1'b1;  wr_addr = 5'd4; wr_data = 32'h11;
        step();
        idle();
        #1;
        total++;
        if (rd_data[63:32] !== 32'h11 || nb_rd_data[63:32] !== 32'h11) begin
            bad++; $display("[TB] FAIL rsvwr_data: got %h/%h expected 11", rd_data[63:32], nb_rd_data[63:32]);
        end
        total++;
        if (rd_busy[1] !== 1'b1 || busy_cnt !== 6'd1) begin
            bad++; $display("[TB] FAIL rsvwr_busy: got busy=%b cnt=%0d expected 1/1", rd_busy[1], busy_cnt);
        end
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h12;
        step();
        idle();
    endtask

    task automatic test_conflict_zero();
        @(negedge clk);
        idle();
        rd_addr = {5'd0, 5'd0};
        rsv_en = 1'b1; rsv_addr = 5'd9;
        #1;
        total++;
        if (rsv_conflict !== 1'b0) begin
            bad++; $display("[TB] FAIL conflict_first: got %b expected 0", rsv_conflict);
        end
        step();
        total++;
        if (rsv_conflict !== 1'b1) begin
            bad++; $display("[TB] FAIL conflict_second: got %b expected 1", rsv_conflict);
        end
        step();
        rsv_en = 1'b0;
        #1;
        total++;
        if (busy_cnt !== 6'd1) begin
            bad++; $display("[TB] FAIL conflict_cnt: got %0d expected 1", busy_cnt);
        end
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9;
        step();
        wr_addr = 5'd0; wr_data = 32'h55;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        rd_used = 2'b01;
        #1;
        total++;
        if (rsv_conflict !== 1'b0 || rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
            bad++; $display("[TB] FAIL zero_same_cycle: got conf=%b data=%h busy=%b expected 0/0/0", rsv_conflict, rd_data[31:0], rd_busy[0]);
        end
        step();
        wr_en = 1'b0; rsv_en = 1'b0;
        #1;
        total++;
        if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0 || busy_cnt !== 6'd0) begin
            bad++; $display("[TB] FAIL zero_after: got data=%h busy=%b cnt=%0d expected 0/0/0", rd_data[31:0], rd_busy[0], busy_cnt);
        end
    endtask

    task automatic test_big_fill();
        @(negedge clk);
        idle();
        b_rd_addr = {6'd63, 6'd20, 6'd10, 6'd0};
        b_rsv_en = 1'b1;
        for (int r = 1; r < 64; r++) begin
            b_rsv_addr = 6'(r);
            step();
        end
        b_rsv_en = 1'b0;
        #1;
        total++;
        if (b_busy_cnt !== 7'd63) begin
            bad++; $display("[TB] FAIL big_full_cnt: got %0d expected 63", b_busy_cnt);
        end
        total++;
        if (b_rd_busy !== 4'b1110) begin
            bad++; $display("[TB] FAIL big_full_busy: got %b expected 1110", b_rd_busy);
        end
        b_wr_en = 1'b1; b_wr_addr = 6'd10; b_wr_data = 32'hA5A5A5A5;
        #1;
        total++;
        if (b_rd_data[63:32] !== 32'hA5A5A5A5 || b_rd_busy !== 4'b1100) begin
            bad++; $display("[TB] FAIL big_port1_bypass: got data=%h busy=%b expected a5a5a5a5/1100", b_rd_data[63:32], b_rd_busy);
        end
        step();
        total++;
        if (b_busy_cnt !== 7'd62) begin
            bad++; $display("[TB] FAIL big_free_one: got %0d expected 62", b_busy_cnt);
        end
        b_rsv_en = 1'b1; b_rsv_addr = 6'd10;
        b_wr_en = 1'b1;  b_wr_addr = 6'd20; b_wr_data = 32'h20;
        #1;
        total++;
        if (b_rsv_conflict !== 1'b0) begin
            bad++; $display("[TB] FAIL big_swap_conflict: got %b expected 0", b_rsv_conflict);
        end
        step();
        idle();
        #1;
        total++;
        if (b_busy_cnt !== 7'd62 || b_rd_busy !== 4'b1010) begin
            bad++; $display("[TB] FAIL big_swap: got cnt=%0d busy=%b expected 62/1010", b_busy_cnt, b_rd_busy);
        end
        total++;
        if (b_rd_data[95:64] !== 32'h20) begin
            bad++; $display("[TB] FAIL big_r20_data: got %h expected 20", b_rd_data[95:64]);
        end
    endtask

    initial begin
        idle();
        rd_addr = '0;
        b_rd_addr = '0;
        test_reset();
        test_reset_midrun();
        test_bypass();
        test_scoreboard();
        test_rsv_wr_same();
        test_conflict_zero();
        test_big_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
